// File: rtl/cmp_pkg.sv
// Shared types for the compare-window statistics block: FSM states, compare
// results and small helpers.
package cmp_pkg;

   typedef enum logic {
      ACCUM  = 1'b0,
      REPORT = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      GT = 2'd0,
      EQ = 2'd1,
      LT = 2'd2
   } cmp_res_e;

   function automatic cmp_res_e cmp_decode(input logic gt, input logic eq, input logic lt);
      cmp_res_e res;
      unique case ({gt, eq, lt})
         3'b100:  res = GT;
         3'b010:  res = EQ;
         default: res = LT;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] abs_diff4(input logic [3:0] a, input logic [3:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/cmp_window_stats_if.sv
// Operand/summary bundle for cmp_window_stats. The max_diff signal exists only
// when CMP_STATS_MAXDIFF_EN is defined.
interface cmp_window_stats_if #(
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       data_a;
   logic [3:0]       data_b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] cnt_gt;
   logic [CNT_W-1:0] cnt_eq;
   logic [CNT_W-1:0] cnt_lt;
`ifdef CMP_STATS_MAXDIFF_EN
   logic [3:0]       max_diff;
`endif

   modport master (
      output in_valid, data_a, data_b, flush, out_ready,
      input  in_ready, out_valid, cnt_gt, cnt_eq, cnt_lt
`ifdef CMP_STATS_MAXDIFF_EN
      , input max_diff
`endif
   );

   modport slave (
      input  in_valid, data_a, data_b, flush, out_ready,
      output in_ready, out_valid, cnt_gt, cnt_eq, cnt_lt
`ifdef CMP_STATS_MAXDIFF_EN
      , output max_diff
`endif
   );

endinterface

// File: rtl/comparator_4b.sv
// Unsigned 4-bit magnitude comparator with one-hot gt/eq/lt outputs.
module comparator_4b (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       gt,
   output logic       eq,
   output logic       lt
);

   assign gt = (a > b);
   assign eq = (a == b);
   assign lt = (a < b);

endmodule

// File: rtl/cmp_window_stats.sv
// Counts A>B / A==B / A<B over windows of WIN_LEN accepted pairs and presents
// each window summary with a valid/ready handshake. CMP_STATS_MAXDIFF_EN adds max_diff.
module cmp_window_stats
   import cmp_pkg::*;
#(
   parameter int WIN_LEN = 8,
   parameter int CNT_W   = $clog2(WIN_LEN + 1)
) (
   input logic               clk,
   input logic               rst_n,
   cmp_window_stats_if.slave bus
);

   localparam int              SMP_W    = $clog2(WIN_LEN);
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WIN_LEN - 1);

   state_e           state_q, state_d;
   logic [SMP_W-1:0] smp_q, smp_d;
   logic [CNT_W-1:0] gt_q, gt_d;
   logic [CNT_W-1:0] eq_q, eq_d;
   logic [CNT_W-1:0] lt_q, lt_d;
`ifdef CMP_STATS_MAXDIFF_EN
   logic [3:0]       max_q, max_d;
   logic [3:0]       diff;
`endif

   logic     cmp_gt, cmp_eq, cmp_lt;
   cmp_res_e cmp_res;

   comparator_4b u_cmp (
      .a  (bus.data_a),
      .b  (bus.data_b),
      .gt (cmp_gt),
      .eq (cmp_eq),
      .lt (cmp_lt)
   );

   assign cmp_res = cmp_decode(cmp_gt, cmp_eq, cmp_lt);
`ifdef CMP_STATS_MAXDIFF_EN
   assign diff    = abs_diff4(bus.data_a, bus.data_b);
`endif

   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
      state_d = state_q;
      smp_d   = smp_q;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
`ifdef CMP_STATS_MAXDIFF_EN
      max_d   = max_q;
`endif
      unique case (state_q)
         ACCUM: begin
            if (bus.flush) begin
               // Flush beats a pair offered in the same cycle.
               smp_d = '0;
               gt_d  = '0;
               eq_d  = '0;
               lt_d  = '0;
`ifdef CMP_STATS_MAXDIFF_EN
               max_d = '0;
`endif
            end else if (bus.in_valid) begin
               unique case (cmp_res)
                  GT:      gt_d = gt_q + CNT_W'(1);
                  EQ:      eq_d = eq_q + CNT_W'(1);
                  default: lt_d = lt_q + CNT_W'(1);
               endcase
`ifdef CMP_STATS_MAXDIFF_EN
               if (diff > max_q) max_d = diff;
`endif
               if (smp_q == SMP_LAST) begin
                  smp_d   = '0;
                  state_d = REPORT;
               end else begin
                  smp_d = smp_q + SMP_W'(1);
               end
            end
         end
         REPORT: begin
            if (bus.out_ready) begin
               gt_d    = '0;
               eq_d    = '0;
               lt_d    = '0;
`ifdef CMP_STATS_MAXDIFF_EN
               max_d   = '0;
`endif
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
      if (!rst_n) begin
         state_q <= ACCUM;
         smp_q   <= '0;
         gt_q    <= '0;
         eq_q    <= '0;
         lt_q    <= '0;
`ifdef CMP_STATS_MAXDIFF_EN
         max_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         smp_q   <= smp_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
`ifdef CMP_STATS_MAXDIFF_EN
         max_q   <= max_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == REPORT);
   assign bus.cnt_gt    = gt_q;
   assign bus.cnt_eq    = eq_q;
   assign bus.cnt_lt    = lt_q;
`ifdef CMP_STATS_MAXDIFF_EN
   assign bus.max_diff  = max_q;
`endif

endmodule

// File: tb/tb_cmp_window_stats.sv
// Directed and randomised-gap bench for cmp_window_stats with WIN_LEN=4.
module tb_cmp_window_stats;

   localparam int WIN_LEN = 4;
   localparam int CNT_W   = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   n_total = 0;
   int   n_bad   = 0;

   cmp_window_stats_if #(.CNT_W(CNT_W)) bus_if ();

   cmp_window_stats #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_counts(input string tag, input int g, input int e, input int l);
      check({tag, ".gt"}, 32'(bus_if.cnt_gt), g);
      check({tag, ".eq"}, 32'(bus_if.cnt_eq), e);
      check({tag, ".lt"}, 32'(bus_if.cnt_lt), l);
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b);
      int guard = 0;
      bus_if.in_valid = 1'b1;
      bus_if.data_a   = a;
      bus_if.data_b   = b;
      while (!bus_if.in_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) check("send_timeout", 0, 1);
      tick();
      bus_if.in_valid = 1'b0;
   endtask

   task automatic send_std4();
      send(4'd5, 4'd3);
      send(4'd2, 4'd2);
      send(4'd1, 4'd9);
      send(4'd7, 4'd7);
   endtask

   initial begin
      int m_gt, m_eq, m_lt, m_n, m_max, windows, cyc;
      logic [3:0] ra, rb;
      logic xin, xout;

      rst_n            = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.data_a    = '0;
      bus_if.data_b    = '0;
      bus_if.flush     = 1'b0;
      bus_if.out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      check("rst_in_ready", 32'(bus_if.in_ready), 1);
      check("rst_out_valid", 32'(bus_if.out_valid), 0);
      check_counts("rst", 0, 0, 0);

      // Back-to-back window, consumer always ready
      bus_if.out_ready = 1'b1;
      send(4'd5, 4'd3);
      check_counts("t1_live", 1, 0, 0);
      send(4'd2, 4'd2);
      send(4'd1, 4'd9);
      send(4'd7, 4'd7);
      check("t1_out_valid", 32'(bus_if.out_valid), 1);
      check("t1_in_ready", 32'(bus_if.in_ready), 0);
      check_counts("t1_sum", 1, 2, 1);
      tick();
      check("t1_report_len", 32'(bus_if.out_valid), 0);
      check("t1_back_ready", 32'(bus_if.in_ready), 1);
      check_counts("t1_clr", 0, 0, 0);

      // Back-pressure: summary held, extra pairs refused
      bus_if.out_ready = 1'b0;
      send_std4();
      for (int i = 0; i < 5; i++) begin
         bus_if.in_valid = 1'b1;
         bus_if.data_a   = 4'd15;
         bus_if.data_b   = 4'd0;
         check("t2_hold_valid", 32'(bus_if.out_valid), 1);
         check("t2_hold_ready", 32'(bus_if.in_ready), 0);
         check_counts("t2_hold", 1, 2, 1);
         tick();
      end
      check_counts("t2_after_hold", 1, 2, 1);
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.in_valid = 1'b0;
      check("t2_done_valid", 32'(bus_if.out_valid), 0);
      check_counts("t2_handshake_drop", 0, 0, 0);

      // Flush in ACCUM drops the coincident pair; flush in REPORT is ignored
      bus_if.out_ready = 1'b0;
      send(4'd9, 4'd1);
      send(4'd9, 4'd1);
      check_counts("t3_pre_flush", 2, 0, 0);
      bus_if.flush    = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.data_a   = 4'd0;
      bus_if.data_b   = 4'd0;
      tick();
      bus_if.flush    = 1'b0;
      bus_if.in_valid = 1'b0;
      check_counts("t3_flushed", 0, 0, 0);
      check("t3_flush_valid", 32'(bus_if.out_valid), 0);
`ifdef CMP_STATS_MAXDIFF_EN
      check("t3_flush_maxdiff", 32'(bus_if.max_diff), 0);
`endif
      send(4'd5, 4'd3);
      send(4'd2, 4'd2);
      send(4'd1, 4'd9);
      check("t3_three_not_full", 32'(bus_if.out_valid), 0);
      send(4'd7, 4'd7);
      check("t3_full_valid", 32'(bus_if.out_valid), 1);
      check_counts("t3_full", 1, 2, 1);
      bus_if.flush = 1'b1;
      tick();
      bus_if.flush = 1'b0;
      check("t3_rep_flush_valid", 32'(bus_if.out_valid), 1);
      check_counts("t3_rep_flush", 1, 2, 1);
      bus_if.out_ready = 1'b1;
      tick();
      check("t3_done_valid", 32'(bus_if.out_valid), 0);

      // Reset mid-window, then boundary operands
      send(4'd3, 4'd1);
      send(4'd3, 4'd3);
      send(4'd1, 4'd3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_counts("t4_rst", 0, 0, 0);
      check("t4_rst_in_ready", 32'(bus_if.in_ready), 1);
      check("t4_rst_out_valid", 32'(bus_if.out_valid), 0);
      tick();
      check("t4_no_summary", 32'(bus_if.out_valid), 0);
      bus_if.out_ready = 1'b0;
      send(4'd15, 4'd0);
      send(4'd0, 4'd15);
      send(4'd15, 4'd15);
      send(4'd0, 4'd0);
      check("t4_valid", 32'(bus_if.out_valid), 1);
      check_counts("t4_bound", 1, 2, 1);
`ifdef CMP_STATS_MAXDIFF_EN
      check("t4_maxdiff", 32'(bus_if.max_diff), 15);
`endif
      bus_if.out_ready = 1'b1;
      tick();
      check("t4_done_valid", 32'(bus_if.out_valid), 0);
`ifdef CMP_STATS_MAXDIFF_EN
      check("t4_maxdiff_clr", 32'(bus_if.max_diff), 0);
`endif

      // Random valid/ready gaps against a scoreboard
      m_gt = 0; m_eq = 0; m_lt = 0; m_n = 0; m_max = 0;
      windows = 0;
      cyc = 0;
      while (windows < 1000 && cyc < 40000) begin
         ra = 4'($urandom_range(15));
         rb = 4'($urandom_range(15));
         bus_if.in_valid  = ($urandom_range(3) != 0);
         bus_if.data_a    = ra;
         bus_if.data_b    = rb;
         bus_if.out_ready = 1'($urandom_range(1));
         check("rnd_in_ready", 32'(bus_if.in_ready), (m_n != WIN_LEN) ? 1 : 0);
         if (!bus_if.out_valid) check_counts("rnd_live", m_gt, m_eq, m_lt);
         xin  = bus_if.in_valid && bus_if.in_ready;
         xout = bus_if.out_valid && bus_if.out_ready;
         if (xout) begin
            check_counts("rnd_sum", m_gt, m_eq, m_lt);
            check("rnd_pairs", 32'(m_n), WIN_LEN);
            check("rnd_total", 32'(bus_if.cnt_gt) + 32'(bus_if.cnt_eq) + 32'(bus_if.cnt_lt), WIN_LEN);
`ifdef CMP_STATS_MAXDIFF_EN
            check("rnd_maxdiff", 32'(bus_if.max_diff), m_max);
`endif
            m_gt = 0; m_eq = 0; m_lt = 0; m_n = 0; m_max = 0;
            windows++;
         end
         if (xin) begin
            if (ra > rb)       m_gt++;
            else if (ra == rb) m_eq++;
            else               m_lt++;
            m_n++;
            if (ra > rb && int'(ra - rb) > m_max) m_max = int'(ra - rb);
            if (rb > ra && int'(rb - ra) > m_max) m_max = int'(rb - ra);
         end
         tick();
         cyc++;
      end
      bus_if.in_valid = 1'b0;
      check("rnd_windows", 32'(windows), 1000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
